data_memory_sized: RTL
======================

DATA_MEMORY_SIZED -- requirements
Module: data_memory_sized

Interface
REQ-001 Parameter DEPTH, default 256: memory size in bytes; power of two, minimum 8.
REQ-002 Parameter FAULT_CNT_W, default 8: width of the fault counter.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port req_valid  input  1  request present.
REQ-006 Port req_ready  output  1  block can accept a request.
REQ-007 Port req_write  input  1  1 = store, 0 = load.
REQ-008 Port req_funct3  input  3  RISC-V access size and sign code.
REQ-009 Port req_addr  input  64  byte address.
REQ-010 Port req_wdata  input  64  store data, right-aligned.
REQ-011 Port resp_valid  output  1  response present.
REQ-012 Port resp_ready  input  1  consumer accepts the response.
REQ-013 Port resp_rdata  output  64  load result, extended to 64 bits.
REQ-014 Port resp_fault  output  1  request was rejected.
REQ-015 Port fault_count  output  FAULT_CNT_W  saturating count of faulted requests.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; a handshake SHALL occur when req_valid and req_ready are both 1 at a rising edge.
REQ-018 On a handshake, the block SHALL register req_write, req_funct3, req_addr and req_wdata, and SHALL move IDLE->ACCESS.
REQ-019 In ACCESS, the block SHALL do the store or load at the next edge, register resp_rdata and resp_fault, and move to RESP.
REQ-020 In RESP, resp_valid SHALL be 1, and resp_rdata and resp_fault SHALL hold stable until an edge where resp_ready=1; that edge SHALL return the FSM to IDLE.
REQ-021 Latency SHALL be as follows: handshake at edge E0, resp_valid high from E1; minimum request spacing is 3 cycles.
REQ-022 Load funct3 SHALL be decoded as: 000 LB, 001 LH, 010 LW, 011 LD (sign-extended); 100 LBU, 101 LHU, 110 LWU (zero-extended).
REQ-023 Store funct3 SHALL be decoded as: 000 SB, 001 SH, 010 SW, 011 SD; store funct3[2]=1 SHALL be illegal.
REQ-024 Load funct3=111 SHALL be illegal.
REQ-025 Byte order SHALL be little-endian: the byte at addr goes to data bits [7:0], and addr+k goes to bits [8k+7:8k].
REQ-026 A store SHALL write exactly size bytes; all other bytes SHALL remain unchanged.
REQ-027 Only the low log2(DEPTH) address bits SHALL index the array; the range check SHALL use the full 64-bit address.
REQ-028 A request SHALL fault when it is illegal, misaligned (addr mod size != 0), or out of range (addr + size > DEPTH, computed without 64-bit overflow).
REQ-029 A faulted request SHALL leave memory unmodified, and SHALL respond with resp_fault=1 and resp_rdata=0.
REQ-030 Every store response SHALL have resp_rdata=0.
REQ-031 fault_count SHALL increment by 1 on the ACCESS->RESP edge of each faulted request, and SHALL saturate at 2^FAULT_CNT_W-1.
REQ-032 Request inputs SHALL be ignored outside IDLE; changing them mid-transaction SHALL not affect the registered request.
REQ-033 resp_ready SHALL be ignored outside RESP.
REQ-034 The memory array SHALL power up all-zero via initialization and SHALL have no reset.

Reset
REQ-035 Asserting reset=0 SHALL force the FSM to IDLE immediately, without waiting for clk.
REQ-036 During reset, outputs SHALL be: req_ready=0, resp_valid=0, resp_rdata=0, resp_fault=0, fault_count=0.
REQ-037 req_ready SHALL become 1 at the first rising edge after reset deasserts.
REQ-038 Reset asserted in ACCESS or RESP SHALL abandon the transaction; a store abandoned before its ACCESS edge SHALL not be written.
REQ-039 Memory contents SHALL be preserved across reset.

Verification
REQ-040 SD addr 0x10 data 0x8877665544332211, then LD 0x10 -> resp_rdata=0x8877665544332211 with resp_fault=0; LBU 0x17 -> 0x88; LB 0x17 -> 0xFFFFFFFFFFFFFF88.
REQ-041 SH addr 0x20 data 0xABCD8001 -> byte 0x20=0x01 and byte 0x21=0x80; LH 0x20 -> 0xFFFFFFFFFFFF8001; LWU 0x20 -> 0x00008001; bytes 0x22-0x27 unchanged.
REQ-042 Faults: SW addr 0x22, LD addr DEPTH-4, store funct3=100, and load funct3=111 -> each gives resp_fault=1, resp_rdata=0, no memory change, and fault_count increments to 4.
REQ-043 Hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stay stable, req_ready stays 0, and req_valid pulses are ignored; resp_ready=1 -> IDLE next edge.
REQ-044 Assert reset mid-ACCESS of SD addr 0x30 -> outputs zero immediately, and a later LD 0x30 returns the prior contents.
REQ-045 Issue 2^FAULT_CNT_W+3 faulted requests -> fault_count saturates at 2^FAULT_CNT_W-1.

Source files
------------

// File: rtl/data_memory_sized.sv
// Byte-addressed data memory serving RISC-V style loads and stores through a
// valid/ready request channel and a valid/ready response channel.
// Each request goes IDLE -> ACCESS -> RESP. Illegal, misaligned or
// out-of-range requests are rejected without touching the array, and a
// saturating counter tallies them.
module data_memory_sized #(
    parameter int DEPTH       = 256,
    parameter int FAULT_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [2:0]             req_funct3,
    input  logic [63:0]            req_addr,
    input  logic [63:0]            req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [63:0]            resp_rdata,
    output logic                   resp_fault,
    output logic [FAULT_CNT_W-1:0] fault_count
);

    localparam int                     AW       = $clog2(DEPTH);
    localparam logic [63:0]            DEPTH_64 = 64'(DEPTH);
    localparam logic [FAULT_CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_s;

    logic                   write_r;
    logic [2:0]             funct3_r;
    logic [63:0]            addr_r;
    logic [63:0]            wdata_r;

    logic                   req_ready_r;
    logic                   resp_valid_r;
    logic [63:0]            resp_rdata_r;
    logic                   resp_fault_r;
    logic [FAULT_CNT_W-1:0] fault_count_r;

    logic [3:0]             size_s;
    logic                   illegal_s;
    logic                   misalign_s;
    logic                   out_of_range_s;
    logic                   fault_s;
    logic [AW-1:0]          idx_s;
    logic [63:0]            rd_word_s;
    logic [63:0]            load_s;

    // Storage has no reset so contents survive reset; it starts out all zero.
    logic [7:0]             mem_r [DEPTH] = '{default: 8'h00};

    assign req_ready   = req_ready_r;
    assign resp_valid  = resp_valid_r;
    assign resp_rdata  = resp_rdata_r;
    assign resp_fault  = resp_fault_r;
    assign fault_count = fault_count_r;

    // FSM state register; reset drops straight back to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; a handshake needs the registered ready.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid && req_ready_r) begin
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                state_s = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Capture the request on the handshake edge only, so later input changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_r  <= 1'b0;
            funct3_r <= 3'd0;
            addr_r   <= 64'd0;
            wdata_r  <= 64'd0;
        end else if (state_r == IDLE && req_valid && req_ready_r) begin
            write_r  <= req_write;
            funct3_r <= req_funct3;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
        end
    end

    // Classify the captured request; the range test avoids forming addr+size.
    always_comb begin
        size_s = 4'd1 << funct3_r[1:0];
        if (write_r) begin
            illegal_s = funct3_r[2];
        end else begin
            illegal_s = (funct3_r == 3'b111);
        end
        misalign_s     = (addr_r & {60'd0, size_s - 4'd1}) != 64'd0;
        out_of_range_s = addr_r > (DEPTH_64 - {60'd0, size_s});
        fault_s        = illegal_s | misalign_s | out_of_range_s;
        idx_s          = addr_r[AW-1:0];
    end

    // Gather eight consecutive bytes little-endian; the size decode trims them.
    always_comb begin
        rd_word_s = 64'd0;
        for (int k = 0; k < 8; k++) begin
            rd_word_s[8*k +: 8] = mem_r[idx_s + AW'(k)];
        end
    end

    // Size the load result and apply sign or zero extension.
    always_comb begin
        load_s = 64'd0;
        case (funct3_r)
            3'b000:  load_s = {{56{rd_word_s[7]}},  rd_word_s[7:0]};
            3'b001:  load_s = {{48{rd_word_s[15]}}, rd_word_s[15:0]};
            3'b010:  load_s = {{32{rd_word_s[31]}}, rd_word_s[31:0]};
            3'b011:  load_s = rd_word_s;
            3'b100:  load_s = {56'd0, rd_word_s[7:0]};
            3'b101:  load_s = {48'd0, rd_word_s[15:0]};
            3'b110:  load_s = {32'd0, rd_word_s[31:0]};
            default: load_s = 64'd0;
        endcase
    end

    // Store exactly size bytes on the ACCESS edge of a legal store.
    always_ff @(posedge clk) begin
        if (state_r == ACCESS && write_r && !fault_s) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < size_s) begin
                    mem_r[idx_s + AW'(k)] <= wdata_r[8*k +: 8];
                end
            end
        end
    end

    // Registered handshake flags, response payload and saturating fault counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready_r   <= 1'b0;
            resp_valid_r  <= 1'b0;
            resp_rdata_r  <= 64'd0;
            resp_fault_r  <= 1'b0;
            fault_count_r <= '0;
        end else begin
            req_ready_r  <= (state_s == IDLE);
            resp_valid_r <= (state_s == RESP);
            if (state_r == ACCESS) begin
                resp_fault_r <= fault_s;
                if (fault_s || write_r) begin
                    resp_rdata_r <= 64'd0;
                end else begin
                    resp_rdata_r <= load_s;
                end
                if (fault_s && fault_count_r != CNT_MAX) begin
                    fault_count_r <= fault_count_r + {{(FAULT_CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule
